// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - game controller event inputs and score/state outputs
interface game_ctrl_if;
  logic        i_animate;
  logic        i_collision;
  logic        i_start;
  logic [1:0]  o_game_state;
  logic [15:0] o_score;
  logic [15:0] o_hi_score;
  logic [2:0]  o_level;

  modport master (
    output i_animate, i_collision, i_start,
    input  o_game_state, o_score, o_hi_score, o_level
  );

  modport slave (
    input  i_animate, i_collision, i_start,
    output o_game_state, o_score, o_hi_score, o_level
  );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - GRACE/PLAY/DEAD game FSM with score, level and hi-score tracking
// Define GAME_CTRL_HISCORE_EN to keep a best-score register; otherwise o_hi_score reads zero.
module game_ctrl #(
  parameter int GRACE_FRAMES = 120,
  parameter int SCORE_DIV    = 6,
  parameter int LEVEL_PTS    = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  game_ctrl_if.slave  bus
);

  localparam int GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;
  localparam int FW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int PW = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;

  localparam logic [GW-1:0] GRACE_LAST = GW'((GRACE_FRAMES > 0) ? GRACE_FRAMES - 1 : 0);
  localparam logic [FW-1:0] FRAME_LAST = FW'((SCORE_DIV > 0) ? SCORE_DIV - 1 : 0);
  localparam logic [PW-1:0] PTS_LAST   = PW'((LEVEL_PTS > 0) ? LEVEL_PTS - 1 : 0);

  typedef enum logic [1:0] {
    ST_GRACE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DEAD  = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [GW-1:0] grace_cnt_q, grace_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW-1:0] pts_cnt_q, pts_cnt_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  level_q, level_d;
  logic        armed_q, armed_d;
`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] hi_q, hi_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_GRACE;
      grace_cnt_q <= '0;
      frame_cnt_q <= '0;
      pts_cnt_q   <= '0;
      score_q     <= '0;
      level_q     <= '0;
      armed_q     <= 1'b0;
`ifdef GAME_CTRL_HISCORE_EN
      hi_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grace_cnt_q <= grace_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pts_cnt_q   <= pts_cnt_d;
      score_q     <= score_d;
      level_q     <= level_d;
      armed_q     <= armed_d;
`ifdef GAME_CTRL_HISCORE_EN
      hi_q        <= hi_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grace_cnt_d = grace_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pts_cnt_d   = pts_cnt_q;
    score_d     = score_q;
    level_d     = level_q;
    armed_d     = 1'b0;
`ifdef GAME_CTRL_HISCORE_EN
    hi_d        = hi_q;
`endif
    case (state_q)
      ST_GRACE: begin
        if (bus.i_animate) grace_cnt_d = grace_cnt_q + GW'(1);
        if ((GRACE_FRAMES == 0) || (bus.i_animate && grace_cnt_q == GRACE_LAST)) begin
          state_d     = ST_PLAY;
          grace_cnt_d = '0;
        end
      end
      ST_PLAY: begin
        if (bus.i_collision) begin
          state_d = ST_DEAD;
`ifdef GAME_CTRL_HISCORE_EN
          if (score_q > hi_q) hi_d = score_q;
`endif
        end else if (bus.i_animate) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            // Saturated score stops level progression as well.
            if (score_q != 16'hFFFF) begin
              score_d = score_q + 16'd1;
              if (pts_cnt_q == PTS_LAST) begin
                pts_cnt_d = '0;
                if (level_q != 3'd7) level_d = level_q + 3'd1;
              end else begin
                pts_cnt_d = pts_cnt_q + PW'(1);
              end
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
        end
      end
      ST_DEAD: begin
        // Restart needs the button seen released inside DEAD, then pressed.
        armed_d = armed_q | ~bus.i_start;
        if (armed_q && bus.i_start) begin
          state_d     = ST_GRACE;
          grace_cnt_d = '0;
          frame_cnt_d = '0;
          pts_cnt_d   = '0;
          score_d     = '0;
          level_d     = '0;
          armed_d     = 1'b0;
        end
      end
      default: state_d = ST_GRACE;
    endcase
  end

  always_comb begin
    bus.o_game_state = state_q;
    bus.o_score      = score_q;
    bus.o_level      = level_q;
`ifdef GAME_CTRL_HISCORE_EN
    bus.o_hi_score   = hi_q;
`else
    bus.o_hi_score   = 16'h0000;
`endif
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl with GRACE_FRAMES=4, SCORE_DIV=2, LEVEL_PTS=2
module tb_game_ctrl;

  localparam logic [1:0] GRACE = 2'b00;
  localparam logic [1:0] PLAY  = 2'b01;
  localparam logic [1:0] DEAD  = 2'b10;
`ifdef GAME_CTRL_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] hi;
    logic [2:0]  lv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  game_ctrl_if bus ();

  game_ctrl #(
    .GRACE_FRAMES(4),
    .SCORE_DIV   (2),
    .LEVEL_PTS   (2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hi_of(int v);
    return HI_EN ? 16'(v) : 16'h0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(string n, logic [1:0] st, int sc, int hi, int lv);
    exp_t e;
    e.name = n;
    e.st   = st;
    e.sc   = 16'(sc);
    e.hi   = hi_of(hi);
    e.lv   = 3'(lv);
    exp_q.push_back(e);
  endtask

  task automatic pulse(int gap);
    bus.i_animate = 1'b1;
    step();
    bus.i_animate = 1'b0;
    for (int g = 0; g < gap; g++) step();
  endtask

  // Monitor: compares every queued expectation against the outputs at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (bus.o_game_state === e.st && bus.o_score === e.sc &&
            bus.o_hi_score === e.hi && bus.o_level === e.lv) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got st=%0d score=%0d hi=%0d level=%0d, want st=%0d score=%0d hi=%0d level=%0d",
                   e.name, bus.o_game_state, bus.o_score, bus.o_hi_score, bus.o_level,
                   e.st, e.sc, e.hi, e.lv);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.i_animate   = 1'b0;
    bus.i_collision = 1'b0;
    bus.i_start     = 1'b0;
    step();
    step();
    expect_o("reset", GRACE, 0, 0, 0);
    rst = 1'b0;
    step();
    expect_o("post_reset_grace", GRACE, 0, 0, 0);

    // Grace ignores collision; fourth animate pulse enters PLAY.
    bus.i_collision = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_animate = 1'b1;
      step();
      bus.i_animate = 1'b0;
      if (i == 3) begin
        bus.i_collision = 1'b0;
        expect_o("grace_to_play", PLAY, 0, 0, 0);
      end else begin
        expect_o("grace_hold", GRACE, 0, 0, 0);
      end
      step();
    end
    expect_o("play_no_dead", PLAY, 0, 0, 0);

    // Scoring: 10 pulses -> score 5, level 2.
    for (int k = 1; k <= 10; k++) begin
      pulse(1);
      expect_o($sformatf("score_p%0d", k), PLAY, k / 2, 0, (k / 2) / 2);
    end

    bus.i_collision = 1'b1;
    bus.i_start     = 1'b1;
    step();
    bus.i_collision = 1'b0;
    expect_o("collide_dead", DEAD, 5, 5, 2);

    // Held button and frame/collision activity in DEAD have no effect.
    for (int c = 0; c < 50; c++) begin
      bus.i_animate   = c[0];
      bus.i_collision = c[1];
      step();
      if (c % 10 == 9) expect_o($sformatf("dead_held_%0d", c), DEAD, 5, 5, 2);
    end
    bus.i_animate   = 1'b0;
    bus.i_collision = 1'b0;
    bus.i_start     = 1'b0;
    step();
    expect_o("dead_released", DEAD, 5, 5, 2);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    expect_o("restart_grace", GRACE, 0, 5, 0);

    for (int i = 0; i < 4; i++) pulse(1);
    expect_o("replay", PLAY, 0, 5, 0);
    for (int i = 0; i < 3; i++) pulse(1);
    expect_o("pre_wrap", PLAY, 1, 5, 0);

    // Collision on the wrapping pulse wins over the score increment.
    bus.i_animate   = 1'b1;
    bus.i_collision = 1'b1;
    step();
    bus.i_animate   = 1'b0;
    bus.i_collision = 1'b0;
    expect_o("collide_vs_wrap", DEAD, 1, 5, 0);
    step();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    expect_o("restart2", GRACE, 0, 5, 0);

    for (int i = 0; i < 4; i++) pulse(1);
    for (int i = 0; i < 6; i++) pulse(1);
    expect_o("score3", PLAY, 3, 5, 1);

    // Reset beats simultaneous animate/collision.
    rst = 1'b1;
    bus.i_animate   = 1'b1;
    bus.i_collision = 1'b1;
    step();
    rst = 1'b0;
    bus.i_animate   = 1'b0;
    bus.i_collision = 1'b0;
    expect_o("reset_in_play", GRACE, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse(1);
    expect_o("grace_count_zero", GRACE, 0, 0, 0);
    pulse(0);
    expect_o("grace_done_again", PLAY, 0, 0, 0);

    // Back-to-back pulses up to level saturation.
    bus.i_animate = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 24) expect_o("level6", PLAY, 12, 0, 6);
      if (k == 28) expect_o("level7", PLAY, 14, 0, 7);
      if (k == 40) expect_o("level_sat", PLAY, 20, 0, 7);
    end
    bus.i_animate   = 1'b0;
    bus.i_collision = 1'b1;
    step();
    bus.i_collision = 1'b0;
    expect_o("final_dead", DEAD, 20, 20, 7);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
